unit_normalize_seq: RTL and testbench
=====================================

// Module: unit_normalize_seq
// PURPOSE
//  Multi-cycle normalizer producing the {exp, 28-bit extended mantissa, ov/un} word consumed by unit_rounding.
//  Takes raw adder/multiplier result (29-bit mantissa incl. carry-out), normalizes hidden bit to o_mant[27],
//  keeps guard/round/sticky in o_mant[3:0]. Sits between FPU datapath core and rounding stage.
//  Valid/ready handshake on both sides; one operation in flight.
// PARAMETERS
//  STEP      4   max left-shift bits per cycle (1..8); window-based leading-zero count
// PORTS
//  i_clk       in   1   clock, all state on rising edge
//  i_rst       in   1   synchronous reset, active-high
//  i_valid     in   1   input word valid
//  o_ready     out  1   block can accept (high only in IDLE)
//  i_exp       in   8   biased exponent of raw result
//  i_mant      in   29  raw mantissa: [28]=carry, [27]=hidden, [26:4]=frac, [3]=G, [2]=R, [1:0]=sticky
//  i_ov_fl     in   1   upstream overflow, passed through (OR'd)
//  i_un_fl     in   1   upstream underflow, passed through (OR'd)
//  o_valid     out  1   output word valid
//  i_ready     in   1   downstream (rounding) accepts
//  o_exp       out  8   normalized exponent
//  o_mant      out  28  normalized mantissa, format of unit_rounding i_mant
//  o_ov_fl     out  1   overflow flag
//  o_un_fl     out  1   underflow flag
// BEHAVIOUR
//  Reset: state=IDLE, o_ready=1, o_valid=0, o_exp=0, o_mant=0, o_ov_fl=0, o_un_fl=0. Reset wins any cycle,
//   incl. mid-SHIFT/DONE; in-flight op discarded, no output.
//  FSM IDLE -> (accept) SHIFT or DONE; SHIFT -> DONE when normalized/underflowed; DONE -> IDLE on i_ready.
//  Accept = i_valid & o_ready (IDLE only). Registers exp/mant(29b)/flags; decides path same edge:
//   - i_mant==0: o_exp=0, o_mant=0, flags=upstream only; -> DONE. Latency 1.
//   - i_mant[28]=1: right shift 1, new bit0 = old bit1|old bit0 (sticky kept); exp+1.
//     If exp+1==255: o_exp=255, o_mant=0, o_ov_fl=1. -> DONE. Latency 1.
//   - i_mant[28:27]==01: pass unchanged -> DONE. Latency 1.
//   - i_exp==0 with nonzero mant, no carry: o_un_fl=1, mant unchanged, exp 0 -> DONE. Latency 1.
//   - else -> SHIFT.
//  SHIFT (per cycle): lz = leading zeros in mant[27:28-STEP] (STEP if all zero); s = min(lz, exp-1);
//   mant <<= s (zeros into bit0), exp -= s. Exit to DONE when mant[27]=1, or exp==1 with mant[27]=0:
//   then o_exp=0, o_un_fl=1, mant kept as shifted (denormal form). Cycles in SHIFT = ceil(nlz/STEP) unless clipped.
//  Latency accept->o_valid: 1 cycle (fast paths), 1+ceil(nlz/STEP) (shift path).
//  DONE: o_valid=1; o_exp/o_mant/flags stable until i_valid handshake o_valid&i_ready; then IDLE next edge,
//   o_valid=0. o_ready=0 in SHIFT and DONE (no bypass; back-to-back throughput >=2 cycles/op).
//  o_ov_fl = upstream ov | computed ov; o_un_fl = upstream un | computed un. Upstream ov does not
//   suppress normalization.
//  Exponent arithmetic 8-bit unsigned, never wraps: increment capped at 255, decrement floored at 1 via s clip.
//  o_mant = internal mant[27:0]; bit 28 always 0 after normalization.
// TESTING
//  exp=0x80, mant=0x1000_0003 (carry) -> 1 cyc: o_exp=0x81, o_mant=0x800_0001 (sticky kept), flags 0.
//  exp=0xFE, mant=0x1800_0000 -> o_exp=0xFF, o_mant=0, o_ov_fl=1, latency 1.
//  STEP=4, exp=0x80, mant=0x000_0100 (nlz=19) -> 5 SHIFT cyc, o_exp=0x6D, o_mant=0x800_0000.
//  exp=0x03, mant=0x000_0010 -> s clipped to 2, o_exp=0, o_mant=0x000_0040, o_un_fl=1.
//  mant=0, i_un_fl=1 -> o_exp=0, o_mant=0, o_un_fl=1; i_ready=0 for 5 cyc -> outputs held, o_ready=0.
//  i_rst pulsed during SHIFT -> next cycle IDLE, o_valid=0, all outputs 0; new op then completes normally.

Source files
------------

// File: rtl/unit_normalize_seq.sv
// Multi-cycle normalizer: aligns the hidden bit of a raw datapath result to o_mant[27]
// and hands {exp, mant, ov, un} to the rounding stage over a valid/ready handshake.
module unit_normalize_seq #(
    parameter int unsigned STEP = 4
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_valid,
    output logic        o_ready,
    input  logic [7:0]  i_exp,
    input  logic [28:0] i_mant,
    input  logic        i_ov_fl,
    input  logic        i_un_fl,
    output logic        o_valid,
    input  logic        i_ready,
    output logic [7:0]  o_exp,
    output logic [27:0] o_mant,
    output logic        o_ov_fl,
    output logic        o_un_fl
);

    localparam int unsigned EW  = 8;
    localparam int unsigned MW  = 29;
    localparam int unsigned LZW = 4;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_state_n;
    logic [EW-1:0]   r_exp;
    logic [EW-1:0]   w_exp_n;
    logic [MW-1:0]   r_mant;
    logic [MW-1:0]   w_mant_n;
    logic            r_ov;
    logic            w_ov_n;
    logic            r_un;
    logic            w_un_n;
    logic            r_valid;
    logic            r_ready;

    logic [LZW-1:0]  w_lz;
    logic [EW-1:0]   w_room;
    logic [EW-1:0]   w_s;
    logic [MW-1:0]   w_shifted;
    logic [EW-1:0]   w_exp_dec;

    // Leading-zero count inside the STEP-wide window just below the hidden-bit position
    always_comb begin
        w_lz = LZW'(STEP);
        for (int i = int'(STEP) - 1; i >= 0; i--) begin
            if (r_mant[27-i]) w_lz = LZW'(i);
        end
    end

    // Shift is clipped so the exponent never drops below 1
    always_comb begin
        w_room    = r_exp - 8'd1;
        w_s       = (EW'(w_lz) > w_room) ? w_room : EW'(w_lz);
        w_shifted = r_mant << w_s;
        w_exp_dec = r_exp - w_s;
    end

    always_comb begin
        w_state_n = r_state;
        w_exp_n   = r_exp;
        w_mant_n  = r_mant;
        w_ov_n    = r_ov;
        w_un_n    = r_un;
        case (r_state)
            S_IDLE: begin
                if (i_valid) begin
                    w_exp_n   = i_exp;
                    w_mant_n  = i_mant;
                    w_ov_n    = i_ov_fl;
                    w_un_n    = i_un_fl;
                    w_state_n = S_DONE;
                    if (i_mant == '0) begin
                        w_exp_n = '0;
                    end else if (i_mant[28]) begin
                        if (i_exp >= 8'd254) begin
                            w_exp_n  = 8'd255;
                            w_mant_n = '0;
                            w_ov_n   = 1'b1;
                        end else begin
                            w_exp_n  = i_exp + 8'd1;
                            w_mant_n = {1'b0, i_mant[28:2], i_mant[1] | i_mant[0]};
                        end
                    end else if (i_mant[27]) begin
                        w_state_n = S_DONE;
                    end else if (i_exp == '0) begin
                        w_un_n = 1'b1;
                    end else begin
                        w_state_n = S_SHIFT;
                    end
                end
            end
            S_SHIFT: begin
                w_mant_n = w_shifted;
                w_exp_n  = w_exp_dec;
                if (w_shifted[27]) begin
                    w_state_n = S_DONE;
                end else if (w_exp_dec == 8'd1) begin
                    // Ran out of exponent: leave mantissa in denormal form
                    w_exp_n   = '0;
                    w_un_n    = 1'b1;
                    w_state_n = S_DONE;
                end
            end
            S_DONE: begin
                if (i_ready) w_state_n = S_IDLE;
            end
            default: w_state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= S_IDLE;
            r_exp   <= '0;
            r_mant  <= '0;
            r_ov    <= 1'b0;
            r_un    <= 1'b0;
            r_valid <= 1'b0;
            r_ready <= 1'b1;
        end else begin
            r_state <= w_state_n;
            r_exp   <= w_exp_n;
            r_mant  <= w_mant_n;
            r_ov    <= w_ov_n;
            r_un    <= w_un_n;
            r_valid <= (w_state_n == S_DONE);
            r_ready <= (w_state_n == S_IDLE);
        end
    end

    assign o_ready = r_ready;
    assign o_valid = r_valid;
    assign o_exp   = r_exp;
    assign o_mant  = r_mant[27:0];
    assign o_ov_fl = r_ov;
    assign o_un_fl = r_un;

endmodule

// File: tb/tb_unit_normalize_seq.sv
// Randomized self-checking bench for unit_normalize_seq against an arithmetic reference model.
module tb_unit_normalize_seq;

    localparam int unsigned STEP = 4;

    logic        clk;
    logic        rst;
    logic        i_valid;
    logic        o_ready;
    logic [7:0]  i_exp;
    logic [28:0] i_mant;
    logic        i_ov_fl;
    logic        i_un_fl;
    logic        o_valid;
    logic        i_ready;
    logic [7:0]  o_exp;
    logic [27:0] o_mant;
    logic        o_ov_fl;
    logic        o_un_fl;

    int n_checks = 0;
    int n_errors = 0;

    unit_normalize_seq #(.STEP(STEP)) dut (
        .i_clk   (clk),
        .i_rst   (rst),
        .i_valid (i_valid),
        .o_ready (o_ready),
        .i_exp   (i_exp),
        .i_mant  (i_mant),
        .i_ov_fl (i_ov_fl),
        .i_un_fl (i_un_fl),
        .o_valid (o_valid),
        .i_ready (i_ready),
        .o_exp   (o_exp),
        .o_mant  (o_mant),
        .o_ov_fl (o_ov_fl),
        .o_un_fl (o_un_fl)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, want);
        end
    endtask

    // Reference: works on whole-number leading-zero counts rather than per-cycle windows
    task automatic model(input int e, input int m, input bit ov, input bit un,
                         output int re, output int rm, output bit rov, output bit run,
                         output int lat);
        int nlz;
        int room;
        rov = ov; run = un; lat = 1;
        if (m == 0) begin
            re = 0; rm = 0;
        end else if (m >= (1 << 28)) begin
            if (e + 1 >= 255) begin
                re = 255; rm = 0; rov = 1'b1;
            end else begin
                re = e + 1; rm = (m >> 1) | (m & 1);
            end
        end else if (m >= (1 << 27)) begin
            re = e; rm = m;
        end else if (e == 0) begin
            re = 0; rm = m; run = 1'b1;
        end else begin
            nlz = 0;
            while (((m << nlz) & (1 << 27)) == 0) nlz++;
            room = e - 1;
            if (nlz <= room) begin
                re = e - nlz; rm = (m << nlz) & 32'h0FFF_FFFF;
                lat = 1 + (nlz + STEP - 1) / STEP;
            end else begin
                re = 0; rm = (m << room) & 32'h0FFF_FFFF; run = 1'b1;
                lat = 1 + ((room == 0) ? 1 : (room + STEP - 1) / STEP);
            end
        end
    endtask

    task automatic run_op(input int e, input int m, input bit ov, input bit un, input int hold);
        int re, rm, lat, n;
        bit rov, run;
        model(e, m, ov, un, re, rm, rov, run, lat);
        n = 0;
        while (!o_ready && n < 50) begin
            @(posedge clk); #1; n++;
        end
        check("ready_before_op", 32'(o_ready), 32'd1);
        i_exp = 8'(e); i_mant = 29'(m); i_ov_fl = ov; i_un_fl = un; i_valid = 1'b1;
        i_ready = 1'b0;
        @(posedge clk); #1;
        i_valid = 1'b0;
        n = 1;
        while (!o_valid && n < 40) begin
            @(posedge clk); #1; n++;
        end
        check("latency", 32'(n), 32'(lat));
        check("o_exp", 32'(o_exp), 32'(re));
        check("o_mant", 32'(o_mant), 32'(rm));
        check("o_ov_fl", 32'(o_ov_fl), 32'(rov));
        check("o_un_fl", 32'(o_un_fl), 32'(run));
        for (int k = 0; k < hold; k++) begin
            @(posedge clk); #1;
            check("hold_valid", 32'(o_valid), 32'd1);
            check("hold_ready", 32'(o_ready), 32'd0);
            check("hold_exp", 32'(o_exp), 32'(re));
            check("hold_mant", 32'(o_mant), 32'(rm));
        end
        i_ready = 1'b1;
        @(posedge clk); #1;
        i_ready = 1'b0;
        check("after_hs_valid", 32'(o_valid), 32'd0);
        check("after_hs_ready", 32'(o_ready), 32'd1);
    endtask

    initial begin
        int e, m, nlz, cat;
        rst = 1'b1; i_valid = 1'b0; i_ready = 1'b0;
        i_exp = '0; i_mant = '0; i_ov_fl = 1'b0; i_un_fl = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_ready", 32'(o_ready), 32'd1);
        check("rst_valid", 32'(o_valid), 32'd0);
        check("rst_exp", 32'(o_exp), 32'd0);
        check("rst_mant", 32'(o_mant), 32'd0);
        check("rst_flags", 32'({o_ov_fl, o_un_fl}), 32'd0);
        rst = 1'b0;

        run_op(32'h80, 32'h1000_0003, 1'b0, 1'b0, 0);
        run_op(32'hFE, 32'h1800_0000, 1'b0, 1'b0, 0);
        run_op(32'h80, 32'h0000_0100, 1'b0, 1'b0, 1);
        run_op(32'h03, 32'h0000_0010, 1'b0, 1'b0, 0);
        run_op(32'h40, 32'h0000_0000, 1'b0, 1'b1, 5);
        run_op(32'hFF, 32'h1000_0000, 1'b0, 1'b0, 0);
        run_op(32'h00, 32'h0400_0000, 1'b1, 1'b0, 0);
        run_op(32'h01, 32'h0200_0000, 1'b0, 1'b0, 0);
        run_op(32'h05, 32'h0000_0001, 1'b1, 1'b0, 2);

        // Reset in the middle of a shift discards the operation
        i_exp = 8'h80; i_mant = 29'h100; i_valid = 1'b1;
        @(posedge clk); #1;
        i_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("midrst_ready", 32'(o_ready), 32'd1);
        check("midrst_valid", 32'(o_valid), 32'd0);
        check("midrst_exp", 32'(o_exp), 32'd0);
        check("midrst_mant", 32'(o_mant), 32'd0);
        repeat (6) begin
            @(posedge clk); #1;
            check("midrst_no_out", 32'(o_valid), 32'd0);
        end
        run_op(32'h80, 32'h0000_0100, 1'b0, 1'b0, 0);

        for (int t = 0; t < 300; t++) begin
            cat = int'($urandom_range(0, 9));
            e = int'($urandom_range(0, 255));
            if (cat == 0) begin
                m = 0;
            end else if (cat == 1) begin
                m = int'($urandom) & 32'h1FFF_FFFF | 32'h1000_0000;
            end else if (cat == 2) begin
                m = int'($urandom) & 32'h0FFF_FFFF | 32'h0800_0000;
            end else begin
                nlz = int'($urandom_range(1, 27));
                m = (int'($urandom) & ((1 << (27 - nlz)) - 1)) | (1 << (27 - nlz));
                if (cat == 3) e = int'($urandom_range(0, 6));
            end
            run_op(e, m, 1'($urandom), 1'($urandom), int'($urandom_range(0, 3)));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
